// File: rtl/green_stream_stats.sv
// Streaming green-pixel classifier: per-frame thresholds, total/left-region
// green counts and leftmost green column, held until the next frame starts.
module green_stream_stats #(
   parameter int WIDTH  = 64,
   parameter int LENGTH = 48,
   parameter int LEFT   = 16,
   parameter int CNT_W  = $clog2(WIDTH*LENGTH+1),
   parameter int COL_W  = $clog2(WIDTH+1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [23:0]      i_lo_thr,
   input  logic [23:0]      i_hi_thr,
   input  logic             i_pix_valid,
   output logic             o_pix_ready,
   input  logic [23:0]      i_pix_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_result_valid,
   output logic [CNT_W-1:0] o_result_sum,
   output logic [CNT_W-1:0] o_result_sum_left,
   output logic             o_result_found,
   output logic [COL_W-1:0] o_result_leftmost
);

   localparam int ROW_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LENGTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [23:0]      r_lo;
   logic [23:0]      r_hi;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [CNT_W-1:0] r_sum;
   logic [CNT_W-1:0] r_sum_left;
   logic             r_found;
   logic [COL_W-1:0] r_lm;
   logic             r_res_valid;
   logic [CNT_W-1:0] r_res_sum;
   logic [CNT_W-1:0] r_res_sum_left;
   logic             r_res_found;
   logic [COL_W-1:0] r_res_lm;

   logic             w_accept;
   logic             w_last;
   logic             w_green;
   logic             w_hit;
   logic             w_in_left;
   logic             w_upd_lm;
   logic [CNT_W-1:0] w_sum_nxt;
   logic [CNT_W-1:0] w_sum_left_nxt;
   logic             w_found_nxt;
   logic [COL_W-1:0] w_lm_nxt;

   // lo > hi on a channel leaves no value in range, so nothing is green
   always_comb begin
      w_green = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (i_pix_data[c*8 +: 8] < r_lo[c*8 +: 8] ||
             i_pix_data[c*8 +: 8] > r_hi[c*8 +: 8])
            w_green = 1'b0;
      end
   end

   generate
      if (LEFT == 0) begin : g_left_none
         assign w_in_left = 1'b0;
      end else if (LEFT >= WIDTH) begin : g_left_all
         assign w_in_left = 1'b1;
      end else begin : g_left_cmp
         assign w_in_left = (r_col < COL_W'(LEFT));
      end
   endgenerate

   assign w_accept       = (r_state == RUN) && i_pix_valid;
   assign w_last         = w_accept && (r_col == LAST_COL) && (r_row == LAST_ROW);
   assign w_hit          = w_accept && w_green;
   assign w_upd_lm       = w_hit && (!r_found || (r_col < r_lm));
   assign w_sum_nxt      = r_sum + CNT_W'(w_hit);
   assign w_sum_left_nxt = r_sum_left + CNT_W'(w_hit && w_in_left);
   assign w_found_nxt    = r_found | w_hit;
   assign w_lm_nxt       = w_upd_lm ? r_col : r_lm;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (i_start) w_state_nxt = RUN;
         RUN:     if (w_last)  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lo           <= '0;
         r_hi           <= '0;
         r_col          <= '0;
         r_row          <= '0;
         r_sum          <= '0;
         r_sum_left     <= '0;
         r_found        <= 1'b0;
         r_lm           <= '0;
         r_res_valid    <= 1'b0;
         r_res_sum      <= '0;
         r_res_sum_left <= '0;
         r_res_found    <= 1'b0;
         r_res_lm       <= '0;
      end else if ((r_state == IDLE) && i_start) begin
         r_lo        <= i_lo_thr;
         r_hi        <= i_hi_thr;
         r_col       <= '0;
         r_row       <= '0;
         r_sum       <= '0;
         r_sum_left  <= '0;
         r_found     <= 1'b0;
         r_lm        <= '0;
         r_res_valid <= 1'b0;
      end else if (w_accept) begin
         r_sum      <= w_sum_nxt;
         r_sum_left <= w_sum_left_nxt;
         r_found    <= w_found_nxt;
         r_lm       <= w_lm_nxt;
         if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
         // publish including the final pixel's contribution
         if (w_last) begin
            r_res_valid    <= 1'b1;
            r_res_sum      <= w_sum_nxt;
            r_res_sum_left <= w_sum_left_nxt;
            r_res_found    <= w_found_nxt;
            r_res_lm       <= w_lm_nxt;
         end
      end
   end

   assign o_pix_ready       = (r_state == RUN);
   assign o_busy            = (r_state != IDLE);
   assign o_done            = (r_state == DONE);
   assign o_result_valid    = r_res_valid;
   assign o_result_sum      = r_res_sum;
   assign o_result_sum_left = r_res_sum_left;
   assign o_result_found    = r_res_found;
   assign o_result_leftmost = r_res_lm;

endmodule

// File: tb/tb_green_stream_stats.sv
// Bench for green_stream_stats: three LEFT variants (0/2/4) on a 4x3 frame,
// driven in lockstep and checked every cycle against a frame-level model.
module tb_green_stream_stats;

   localparam int W = 4;
   localparam int L = 3;
   localparam int N = W * L;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic        i_pix_valid;
   logic [23:0] i_lo;
   logic [23:0] i_hi;
   logic [23:0] i_pix_data;

   logic        o_ready [3];
   logic        o_busy  [3];
   logic        o_done  [3];
   logic        o_rv    [3];
   logic [3:0]  o_sum   [3];
   logic [3:0]  o_sl    [3];
   logic        o_found [3];
   logic [2:0]  o_lm    [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      green_stream_stats #(.WIDTH(W), .LENGTH(L), .LEFT(g*2)) u_dut (
         .i_clk             (clk),
         .i_rst             (i_rst),
         .i_start           (i_start),
         .i_lo_thr          (i_lo),
         .i_hi_thr          (i_hi),
         .i_pix_valid       (i_pix_valid),
         .o_pix_ready       (o_ready[g]),
         .i_pix_data        (i_pix_data),
         .o_busy            (o_busy[g]),
         .o_done            (o_done[g]),
         .o_result_valid    (o_rv[g]),
         .o_result_sum      (o_sum[g]),
         .o_result_sum_left (o_sl[g]),
         .o_result_found    (o_found[g]),
         .o_result_leftmost (o_lm[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   int exp_ready, exp_busy, exp_done, exp_rv;
   int exp_sum, exp_found, exp_lm;
   int exp_sl [3];
   int new_sum, new_found, new_lm;
   int new_sl [3];
   logic [23:0] pix [N];

   function automatic void chk(input string nm, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, k, $time, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk("pix_ready", k, 32'(o_ready[k]), exp_ready);
            chk("busy",      k, 32'(o_busy[k]),  exp_busy);
            chk("done",      k, 32'(o_done[k]),  exp_done);
            chk("res_valid", k, 32'(o_rv[k]),    exp_rv);
            chk("sum",       k, 32'(o_sum[k]),   exp_sum);
            chk("sum_left",  k, 32'(o_sl[k]),    exp_sl[k]);
            chk("found",     k, 32'(o_found[k]), exp_found);
            chk("leftmost",  k, 32'(o_lm[k]),    exp_lm);
         end
      end
   end

   function automatic bit is_green(input logic [23:0] p, input logic [23:0] lo,
                                   input logic [23:0] hi);
      for (int c = 0; c < 3; c++)
         if (p[c*8 +: 8] < lo[c*8 +: 8] || p[c*8 +: 8] > hi[c*8 +: 8]) return 1'b0;
      return 1'b1;
   endfunction

   // Whole-frame answer: counts by scanning the image, leftmost by column scan
   function automatic void model(input logic [23:0] lo, input logic [23:0] hi);
      new_sum = 0; new_found = 0; new_lm = 0;
      for (int k = 0; k < 3; k++) new_sl[k] = 0;
      for (int c = 0; c < W; c++)
         for (int r = 0; r < L; r++)
            if (is_green(pix[r*W + c], lo, hi)) begin
               new_sum++;
               for (int k = 0; k < 3; k++) if (c < 2*k) new_sl[k]++;
               if (new_found == 0) begin new_found = 1; new_lm = c; end
            end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reset_exp();
      exp_ready = 0; exp_busy = 0; exp_done = 0; exp_rv = 0;
      exp_sum = 0; exp_found = 0; exp_lm = 0;
      for (int k = 0; k < 3; k++) exp_sl[k] = 0;
   endtask

   task automatic run_frame(input logic [23:0] lo, input logic [23:0] hi,
                            input bit gaps, input bit noise,
                            input int idle_cyc, input int abort_at);
      int idx;
      int cyc;
      bit v;
      for (int i = 0; i < idle_cyc; i++) begin
         i_pix_valid = 1'b1;
         i_pix_data  = 24'h208020;
         step();
      end
      i_pix_valid = 1'b0;
      i_start = 1'b1;
      i_lo = lo;
      i_hi = hi;
      model(lo, hi);
      step();
      exp_ready = 1; exp_busy = 1; exp_rv = 0;
      i_start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < N && cyc < 200) begin
         if (abort_at >= 0 && idx == abort_at) begin
            i_rst = 1'b1;
            i_pix_valid = 1'b0;
            set_reset_exp();
            step();
            i_rst = 1'b0;
            return;
         end
         v = gaps ? ($urandom % 3 != 0) : 1'b1;
         i_pix_valid = v;
         i_pix_data  = v ? pix[idx] : 24'($urandom);
         if (noise) begin
            i_start = 1'($urandom % 2);
            i_lo = 24'($urandom);
            i_hi = 24'($urandom);
         end
         step();
         cyc++;
         if (v) idx++;
         if (idx == N) begin
            exp_ready = 0; exp_done = 1; exp_rv = 1;
            exp_sum = new_sum; exp_found = new_found; exp_lm = new_lm;
            for (int k = 0; k < 3; k++) exp_sl[k] = new_sl[k];
         end
      end
      if (idx < N) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_timeout: accepted %0d of %0d pixels", idx, N);
      end
      i_pix_valid = 1'($urandom % 2);
      i_start = noise;
      step();
      exp_done = 0; exp_busy = 0;
      i_start = 1'b0;
      i_pix_valid = 1'b0;
   endtask

   task automatic lit(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      chk(nm, k, act, exp);
   endtask

   logic [23:0] LO = 24'h008000;
   logic [23:0] HI = 24'h40FF40;
   logic [23:0] GRN = 24'h208020;

   initial begin
      logic [23:0] rlo, rhi, p;
      int a, b;
      i_rst = 1'b1;
      i_start = 1'b0;
      i_pix_valid = 1'b0;
      i_lo = '0;
      i_hi = '0;
      i_pix_data = '0;
      set_reset_exp();
      @(negedge clk);
      chk_en = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      step();

      // all black
      for (int i = 0; i < N; i++) pix[i] = 24'h000000;
      run_frame(LO, HI, 0, 0, 2, -1);
      lit("lit_black_sum", 1, 32'(o_sum[1]), 0);
      lit("lit_black_found", 1, 32'(o_found[1]), 0);
      lit("lit_black_rv", 1, 32'(o_rv[1]), 1);

      // four green pixels
      for (int i = 0; i < N; i++) pix[i] = 24'h000000;
      pix[3] = GRN; pix[5] = GRN; pix[9] = GRN; pix[8] = GRN;
      run_frame(LO, HI, 0, 0, 1, -1);
      lit("lit_g4_sum", 1, 32'(o_sum[1]), 4);
      lit("lit_g4_left", 1, 32'(o_sl[1]), 3);
      lit("lit_g4_left0", 0, 32'(o_sl[0]), 0);
      lit("lit_g4_left4", 2, 32'(o_sl[2]), 4);
      lit("lit_g4_lm", 1, 32'(o_lm[1]), 0);

      // same frame with gaps, stray start and moving thresholds
      run_frame(LO, HI, 1, 1, 0, -1);
      lit("lit_noise_sum", 1, 32'(o_sum[1]), 4);
      lit("lit_noise_left", 1, 32'(o_sl[1]), 3);

      // threshold boundaries
      for (int i = 0; i < N; i++) pix[i] = 24'h000000;
      pix[1] = LO; pix[6] = HI; pix[11] = 24'h40FF41;
      run_frame(LO, HI, 0, 0, 0, -1);
      lit("lit_bnd_sum", 1, 32'(o_sum[1]), 2);
      lit("lit_bnd_lm", 1, 32'(o_lm[1]), 1);

      // abort then all green
      for (int i = 0; i < N; i++) pix[i] = GRN;
      run_frame(LO, HI, 0, 0, 1, 5);
      run_frame(LO, HI, 0, 0, 1, -1);
      lit("lit_all_sum", 1, 32'(o_sum[1]), 12);
      lit("lit_all_left", 1, 32'(o_sl[1]), 6);
      lit("lit_all_left0", 0, 32'(o_sl[0]), 0);
      lit("lit_all_left4", 2, 32'(o_sl[2]), 12);

      // inverted thresholds: nothing green
      run_frame(24'h00FF00, 24'h40FE40, 0, 0, 0, -1);

      // randomized frames, mostly back-to-back
      for (int f = 0; f < 10; f++) begin
         for (int c = 0; c < 3; c++) begin
            a = $urandom_range(150, 0);
            b = a + $urandom_range(100, 0);
            if (b > 255) b = 255;
            if ($urandom % 6 == 0) begin
               rlo[c*8 +: 8] = 8'(b); rhi[c*8 +: 8] = 8'(a == b ? a - 1 : a);
            end else begin
               rlo[c*8 +: 8] = 8'(a); rhi[c*8 +: 8] = 8'(b);
            end
         end
         for (int i = 0; i < N; i++) begin
            for (int c = 0; c < 3; c++) begin
               if (rlo[c*8 +: 8] <= rhi[c*8 +: 8] && $urandom % 4 != 0)
                  p[c*8 +: 8] = 8'($urandom_range(rhi[c*8 +: 8], rlo[c*8 +: 8]));
               else
                  p[c*8 +: 8] = 8'($urandom);
            end
            pix[i] = p;
         end
         run_frame(rlo, rhi, f[0], f >= 5, (f % 3 == 0) ? 2 : 0, -1);
      end

      step();
      step();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/green_stream_stats.md
# green_stream_stats

Streaming, parametrised successor to the whole-frame green-hand classifier. Accepts one 3-channel pixel per handshake in raster order and classifies it against runtime thresholds latched per frame. Accumulates the total green-pixel count, the green count in the left region, and the leftmost column containing green. Sits between the camera/frame source and the rock-paper-scissors decision logic; results are registered and held until the next frame starts.

## Interface
- WIDTH, 64: pixels per row (≥1)
- LENGTH, 48: rows per frame (≥1)
- LEFT, 16: columns 0..LEFT-1 form the left region (0..WIDTH)
- CNT_W, $clog2(WIDTH*LENGTH+1): counter width
- COL_W, $clog2(WIDTH+1): column index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- lo_thr  in  24  inclusive lower thresholds: ch0=[7:0], ch1=[15:8], ch2=[23:16]; latched on start
- hi_thr  in  24  inclusive upper thresholds, same packing; latched on start
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  block accepts a pixel (high only in RUN)
- pix_data  in  24  pixel, same channel packing as thresholds
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, frame complete
- result_valid  out  1  result_* hold a completed frame
- result_sum  out  CNT_W  green pixels in frame
- result_sum_left  out  CNT_W  green pixels with column < LEFT
- result_found  out  1  at least one green pixel in frame
- result_leftmost  out  COL_W  lowest column index containing green; 0 when result_found=0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: pix_ready=0. start=1 → latch lo_thr/hi_thr, clear accumulators, row/col counters, found flag; clear result_valid; next RUN.
- RUN: pix_ready=1. Accept on pix_valid&pix_ready. Pixel is green iff every channel c satisfies lo[c] ≤ data[c] ≤ hi[c] (unsigned, inclusive). lo>hi on any channel → no pixel is green.
- On accepted green pixel: sum+=1; if col<LEFT, sum_left+=1; if !found or col<leftmost, leftmost=col, found=1.
- Raster: col increments per accepted pixel; at col=WIDTH-1 wrap to 0 and row+=1. Acceptance at row=LENGTH-1, col=WIDTH-1 is the last pixel → next DONE.
- Results copied to result_* on the same edge that enters DONE (last pixel included); result_valid set on that edge.
- DONE: one cycle, done=1, pix_ready=0; next IDLE unconditionally. start in DONE ignored.
- start in RUN ignored; thresholds not re-latched mid-frame. pix_valid outside RUN ignored (no acceptance).
- LEFT=0 → result_sum_left always 0; LEFT≥WIDTH → result_sum_left = result_sum.
- Counters cannot overflow (CNT_W sized for WIDTH*LENGTH).

## Timing
- Reset (async assert, any state): state=IDLE, pix_ready=0, busy=0, done=0, result_valid=0, all result_* = 0, accumulators/counters/latched thresholds = 0.
- start sampled at edge S → RUN from S; pix_ready high in the cycle after S.
- Throughput one pixel/cycle; back-pressure only via pix_valid low (block never stalls in RUN).
- No stalls: last pixel accepted at edge S+WIDTH*LENGTH; done high for the following cycle; busy falls one edge later.
- result_* change only on entering DONE or on reset; stable and readable from DONE until next accepted start (result_valid drops on that edge; result_* keep old values until next DONE).
- Reset mid-frame: partial frame discarded; no done pulse.

## Test plan
- WIDTH=4, LENGTH=3, LEFT=2, thresholds lo=0x00_80_00 hi=0x40_FF_40; frame all black (0x000000) → done once after 12 accepted pixels, result_sum=0, sum_left=0, found=0, leftmost=0, result_valid=1.
- Same config, green (0x208020) at (r0,c3),(r1,c1),(r2,c1),(r2,c0) → sum=4, sum_left=3, found=1, leftmost=0.
- Boundary thresholds: pixel exactly lo and exactly hi per channel both green; one channel at hi+1 not green → sum=2 for a 2-green frame.
- pix_valid toggled 1-0-1 with random gaps, start pulsed mid-RUN, pix_data changed with thresholds inputs changed mid-frame → results identical to gap-free run with original thresholds; done exactly once.
- rst asserted after 5 pixels, then new frame of all green → no done for aborted frame; new frame sum=12, sum_left=6, leftmost=0.
- LEFT=0 and LEFT=4 variants on an all-green frame → sum_left=0 and 12 respectively; back-to-back frames (start in cycle after done) give correct independent results.
